// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Drives the left/right shift-event inputs of a BIT_DEPTH-bit shift register.
//   In manual mode, rising edges on the synchronized button levels become
//   one-cycle shift events. In auto mode, the register is cleared and seeded
//   with a single 1, and that bit then bounces between LSB and MSB at a rate
//   set by the prescaler period.
//
//   Optional build macro SHIFT_SEQ_COUNTER_EN adds a 16-bit event_count output
//   that counts the cycles in which any shift event is high.
//
// Ports
//   clk                system clock
//   reset              synchronous, active-high reset
//   left_req/right_req synchronized button levels; a rising edge is a request
//   left_bit_in        data bit for a manual left shift
//   right_bit_in       data bit for a manual right shift
//   auto_mode          1 = bounce mode, 0 = manual mode
//   period             clocks per bounce step (0 behaves as 1)
//   left_shift_event   pulse: shift toward MSB, left_shift_bit enters at LSB
//   left_shift_bit     data bit for the left shift
//   right_shift_event  pulse: shift toward LSB, right_shift_bit enters at MSB
//   right_shift_bit    data bit for the right shift
//   position           index of the lit bit in auto mode, 0 otherwise
//   state              FSM state, for debug LEDs
//   event_count        (SHIFT_SEQ_COUNTER_EN only) number of event cycles
//
// States
//   state    | meaning
//   IDLE     | out of reset, picks manual or auto on the next clock
//   MANUAL   | button edges become shift events
//   CLEAR    | BIT_DEPTH back-to-back left shifts of 0
//   SEED     | one left shift of 1 (lit bit at position 0)
//   SWEEP_L  | lit bit moves MSB-ward once per tick
//   SWEEP_R  | lit bit moves LSB-ward once per tick

module shift_sequencer #(
    parameter int BIT_DEPTH      = 8,
    parameter int PRESCALE_WIDTH = 26
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          left_req,
    input  logic                          right_req,
    input  logic                          left_bit_in,
    input  logic                          right_bit_in,
    input  logic                          auto_mode,
    input  logic [PRESCALE_WIDTH-1:0]     period,
    output logic                          left_shift_event,
    output logic                          left_shift_bit,
    output logic                          right_shift_event,
    output logic                          right_shift_bit,
    output logic [$clog2(BIT_DEPTH)-1:0]  position,
    output logic [2:0]                    state
`ifdef SHIFT_SEQ_COUNTER_EN
    ,
    output logic [15:0]                   event_count
`endif
);

    localparam int POS_W = $clog2(BIT_DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MANUAL  = 3'd1;
    localparam logic [2:0] ST_CLEAR   = 3'd2;
    localparam logic [2:0] ST_SEED    = 3'd3;
    localparam logic [2:0] ST_SWEEP_L = 3'd4;
    localparam logic [2:0] ST_SWEEP_R = 3'd5;

    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(BIT_DEPTH - 1);
    // Position from which one more left step lands on the MSB.
    localparam logic [POS_W-1:0] POS_TURN_L = POS_W'(BIT_DEPTH - 2);
    localparam logic [POS_W-1:0] POS_TURN_R = POS_W'(1);

    logic                      left_req_q;
    logic                      right_req_q;
    logic                      right_pend;
    logic                      right_pend_bit;
    logic [POS_W-1:0]          clear_cnt;
    logic [PRESCALE_WIDTH-1:0] presc_cnt;
    logic [PRESCALE_WIDTH-1:0] presc_last;
    logic                      left_rise;
    logic                      right_rise;
    logic                      tick;
    logic                      presc_wrap;

    assign left_rise  = left_req & ~left_req_q;
    assign right_rise = right_req & ~right_req_q;

    // period 0 behaves as 1, i.e. a tick every clock.
    assign presc_last = (period == '0) ? '0 : period - PRESCALE_WIDTH'(1);
    assign tick       = (presc_cnt == presc_last);
    // A period shrunk below the current count wraps at once (no tick).
    assign presc_wrap = (presc_cnt >= presc_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            position          <= '0;
            left_shift_event  <= 1'b0;
            left_shift_bit    <= 1'b0;
            right_shift_event <= 1'b0;
            right_shift_bit   <= 1'b0;
            left_req_q        <= 1'b0;
            right_req_q       <= 1'b0;
            right_pend        <= 1'b0;
            right_pend_bit    <= 1'b0;
            clear_cnt         <= '0;
            presc_cnt         <= '0;
        end else begin
            left_req_q        <= left_req;
            right_req_q       <= right_req;
            left_shift_event  <= 1'b0;
            left_shift_bit    <= 1'b0;
            right_shift_event <= 1'b0;
            right_shift_bit   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    clear_cnt <= '0;
                    state     <= auto_mode ? ST_CLEAR : ST_MANUAL;
                end

                ST_MANUAL: begin
                    if (auto_mode) begin
                        state          <= ST_CLEAR;
                        clear_cnt      <= '0;
                        right_pend     <= 1'b0;
                        right_pend_bit <= 1'b0;
                    end else if (left_rise) begin
                        // Left wins a tie; right waits one cycle.
                        left_shift_event <= 1'b1;
                        left_shift_bit   <= left_bit_in;
                        if (right_rise && !right_pend) begin
                            right_pend     <= 1'b1;
                            right_pend_bit <= right_bit_in;
                        end
                    end else if (right_pend) begin
                        // Any new right edge in this cycle is dropped.
                        right_shift_event <= 1'b1;
                        right_shift_bit   <= right_pend_bit;
                        right_pend        <= 1'b0;
                    end else if (right_rise) begin
                        right_shift_event <= 1'b1;
                        right_shift_bit   <= right_bit_in;
                    end
                end

                ST_CLEAR, ST_SEED, ST_SWEEP_L, ST_SWEEP_R: begin
                    if (!auto_mode) begin
                        state     <= ST_MANUAL;
                        position  <= '0;
                        presc_cnt <= '0;
                        clear_cnt <= '0;
                    end else if (state == ST_CLEAR) begin
                        left_shift_event <= 1'b1;
                        if (clear_cnt == POS_LAST) begin
                            clear_cnt <= '0;
                            state     <= ST_SEED;
                        end else begin
                            clear_cnt <= clear_cnt + POS_W'(1);
                        end
                    end else if (state == ST_SEED) begin
                        left_shift_event <= 1'b1;
                        left_shift_bit   <= 1'b1;
                        position         <= '0;
                        presc_cnt        <= '0;
                        state            <= ST_SWEEP_L;
                    end else begin
                        presc_cnt <= presc_wrap ? '0 : presc_cnt + PRESCALE_WIDTH'(1);
                        if (tick) begin
                            if (state == ST_SWEEP_L) begin
                                left_shift_event <= 1'b1;
                                position         <= position + POS_W'(1);
                                if (position == POS_TURN_L)
                                    state <= ST_SWEEP_R;
                            end else begin
                                right_shift_event <= 1'b1;
                                position          <= position - POS_W'(1);
                                if (position == POS_TURN_R)
                                    state <= ST_SWEEP_L;
                            end
                        end
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    position <= '0;
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset)
            event_count <= '0;
        else if (left_shift_event || right_shift_event)
            event_count <= event_count + 16'd1;
    end
`endif

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Controller that drives the left/right shift-event inputs of the board's BIT_DEPTH-bit shift register.
- Arbitrates manual shift requests coming from synchronized push-buttons.
- Provides an autonomous "bouncing single bit" mode (clear, seed, then sweep MSB-ward and back) paced by a programmable prescaler.
- Sits between the button synchronizers and the shift register in the DE2-115 top level.

Parameters:
BIT_DEPTH, 8, width of the controlled shift register; must be >= 2.
PRESCALE_WIDTH, 26, width of the period input and the internal tick counter.

Ports:
clk  input  1  system clock (CLOCK_50 in the top level)
reset  input  1  synchronous, active-high reset
left_req  input  1  level request from a synchronized button; active high
right_req  input  1  level request from a synchronized button; active high
left_bit_in  input  1  bit to shift in on a manual left shift
right_bit_in  input  1  bit to shift in on a manual right shift
auto_mode  input  1  1 = autonomous bounce mode, 0 = manual mode
period  input  PRESCALE_WIDTH  clocks per auto step; 0 is treated as 1
left_shift_event  output  1  one-cycle pulse: register shifts toward MSB, left_shift_bit enters at LSB
left_shift_bit  output  1  data bit for left shift
right_shift_event  output  1  one-cycle pulse: register shifts toward LSB, right_shift_bit enters at MSB
right_shift_bit  output  1  data bit for right shift
position  output  $clog2(BIT_DEPTH)  index of the lit bit in auto mode; 0 otherwise
state  output  3  FSM state encoding, for debug LEDs

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - All outputs 0; state = IDLE; position = 0.
  - Prescaler = 0; pending flags = 0.
  - Registered copies of left_req/right_req = 0.
- All outputs are registered.
- left_shift_event and right_shift_event are never high in the same cycle.
- Edge detection:
  - A request is a rising edge: sampled 1 at the current edge, 0 at the previous edge.
  - A held button produces exactly one request.
- FSM states: IDLE(0), MANUAL(1), CLEAR(2), SEED(3), SWEEP_L(4), SWEEP_R(5).
- IDLE:
  - auto_mode=0 -> MANUAL.
  - auto_mode=1 -> CLEAR, with the clear counter = 0.
- MANUAL:
  - A rising edge sampled at edge N pulses the matching event during cycle N+1, with the bit output = the corresponding *_bit_in sampled at edge N.
  - Simultaneous left and right edges: left is served at N+1; right is held in a pending flag and served at N+2.
  - A new edge while the pending flag for that side is already set is dropped.
  - auto_mode=1 -> CLEAR; pending flags are cleared and no further manual events are issued.
- CLEAR:
  - Issues BIT_DEPTH consecutive left events with left_shift_bit=0, one per clock, not prescaler-gated.
  - Then -> SEED.
- SEED:
  - Issues one left event with left_shift_bit=1.
  - position=0, prescaler=0, then -> SWEEP_L.
- SWEEP_L:
  - On each tick, issues a left event with bit 0 and increments position.
  - When position becomes BIT_DEPTH-1 -> SWEEP_R.
- SWEEP_R:
  - On each tick, issues a right event with bit 0 and decrements position.
  - When position becomes 0 -> SWEEP_L.
- Tick:
  - The prescaler counts 0..max(period,1)-1.
  - Tick = the cycle the count equals max(period,1)-1; the counter then wraps to 0.
  - A period change takes effect at the next wrap; if the counter already exceeds the new limit, it wraps immediately.
- auto_mode=0 while in CLEAR, SEED or a sweep:
  - Next clock -> MANUAL; events stop immediately; position=0; prescaler=0.
- Reset mid-operation overrides everything at that edge: no event is issued in the following cycle.
- Manual request inputs are ignored in every auto state.

Optional Feature:
SHIFT_SEQ_COUNTER_EN
- Defined:
  - Adds output port event_count [15:0], reset to 0.
  - Increments by 1 on every cycle in which either event is high; wraps 0xFFFF -> 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then left_req held high for 10 cycles with left_bit_in=1, auto_mode=0 -> exactly one left_shift_event, with left_shift_bit=1, one cycle after the first high sample.
- left_req and right_req rising on the same edge N, right_bit_in=1 -> left event at N+1, right event with bit 1 at N+2, never both in one cycle.
- auto_mode=1, BIT_DEPTH=8, period=4 -> the shift register shows:
  - 8 back-to-back left events with bit 0, then one with bit 1, giving register 0x01;
  - then one left event every 4 clocks, position walking 0..7;
  - then right events walking 7..0; register reads 0x80 at position 7.
- period=0 in auto mode -> one sweep event every clock; position reaches 7 after 7 ticks following SEED.
- auto_mode dropped during SWEEP_R at position 5 -> next clock state=MANUAL, position=0, no further events; a subsequent right_req edge produces one right event.
- reset asserted during CLEAR (after 3 events) -> next cycle all outputs 0 and state=IDLE; with SHIFT_SEQ_COUNTER_EN, event_count=0.
